// File: rtl/ahblite_master_arbiter.sv
// Two-master AHB-Lite arbiter: CPU (M0) and DMA (M1) share one downstream port.
// Losing requests are parked in per-port hold registers and replayed in a later cycle.
module ahblite_master_arbiter (
    input  logic        HCLK,
    input  logic        HRESET,
    // M0 (CPU)
    input  logic [31:0] HADDR_M0,
    input  logic [1:0]  HTRANS_M0,
    input  logic        HWRITE_M0,
    input  logic [2:0]  HSIZE_M0,
    input  logic [2:0]  HBURST_M0,
    input  logic [3:0]  HPROT_M0,
    input  logic        HMASTLOCK_M0,
    input  logic [31:0] HWDATA_M0,
    output logic        HREADY_M0,
    output logic [31:0] HRDATA_M0,
    output logic        HRESP_M0,
    // M1 (DMA)
    input  logic [31:0] HADDR_M1,
    input  logic [1:0]  HTRANS_M1,
    input  logic        HWRITE_M1,
    input  logic [2:0]  HSIZE_M1,
    input  logic [2:0]  HBURST_M1,
    input  logic [3:0]  HPROT_M1,
    input  logic        HMASTLOCK_M1,
    input  logic [31:0] HWDATA_M1,
    output logic        HREADY_M1,
    output logic [31:0] HRDATA_M1,
    output logic        HRESP_M1,
    // interconnect
    output logic [31:0] HADDR,
    output logic [1:0]  HTRANS,
    output logic        HWRITE,
    output logic [2:0]  HSIZE,
    output logic [2:0]  HBURST,
    output logic [3:0]  HPROT,
    output logic        HMASTLOCK,
    output logic [31:0] HWDATA,
    input  logic        HREADY,
    input  logic [31:0] HRDATA,
    input  logic        HRESP
);

    typedef enum logic [1:0] {GNT_NONE, GNT_M0, GNT_M1} gnt_t;

    typedef struct packed {
        logic [31:0] addr;
        logic [1:0]  trans;
        logic        write;
        logic [2:0]  size;
        logic [2:0]  burst;
        logic [3:0]  prot;
        logic        lock;
    } req_t;

    gnt_t grant, sel, dp_owner, last;
    req_t live0, live1, hold0, hold1, cur0, cur1, bus;
    logic pend0, pend1, live_v0, live_v1, req0, req1;

    assign live0 = {HADDR_M0, HTRANS_M0, HWRITE_M0, HSIZE_M0, HBURST_M0, HPROT_M0, HMASTLOCK_M0};
    assign live1 = {HADDR_M1, HTRANS_M1, HWRITE_M1, HSIZE_M1, HBURST_M1, HPROT_M1, HMASTLOCK_M1};

    // Master-facing response: data-phase owner sees the slave, a parked port is stalled.
    always_comb begin
        HREADY_M0 = 1'b1;
        HRESP_M0  = 1'b0;
        HRDATA_M0 = '0;
        if (dp_owner == GNT_M0) begin
            HREADY_M0 = HREADY;
            HRESP_M0  = HRESP;
            HRDATA_M0 = HRDATA;
        end else if (pend0) begin
            HREADY_M0 = 1'b0;
        end
    end

    always_comb begin
        HREADY_M1 = 1'b1;
        HRESP_M1  = 1'b0;
        HRDATA_M1 = '0;
        if (dp_owner == GNT_M1) begin
            HREADY_M1 = HREADY;
            HRESP_M1  = HRESP;
            HRDATA_M1 = HRDATA;
        end else if (pend1) begin
            HREADY_M1 = 1'b0;
        end
    end

    assign live_v0 = HREADY_M0 & HTRANS_M0[1];
    assign live_v1 = HREADY_M1 & HTRANS_M1[1];
    assign cur0    = pend0 ? hold0 : live0;
    assign cur1    = pend1 ? hold1 : live1;
    assign req0    = pend0 | live_v0;
    assign req1    = pend1 | live_v1;

    // Bursts (SEQ) and locked sequences keep the current owner; otherwise round-robin.
    always_comb begin
        sel = GNT_NONE;
        if (grant == GNT_M0 && (cur0.trans == 2'b11 || cur0.lock)) begin
            sel = GNT_M0;
        end else if (grant == GNT_M1 && (cur1.trans == 2'b11 || cur1.lock)) begin
            sel = GNT_M1;
        end else if (req0 && req1) begin
            sel = (last == GNT_M0) ? GNT_M1 : GNT_M0;
        end else if (req0) begin
            sel = GNT_M0;
        end else if (req1) begin
            sel = GNT_M1;
        end
    end

    always_comb begin
        case (sel)
            GNT_M0:  bus = cur0;
            GNT_M1:  bus = cur1;
            default: bus = '0;
        endcase
    end

    assign HADDR     = bus.addr;
    assign HTRANS    = bus.trans;
    assign HWRITE    = bus.write;
    assign HSIZE     = bus.size;
    assign HBURST    = bus.burst;
    assign HPROT     = bus.prot;
    assign HMASTLOCK = bus.lock;

    always_comb begin
        case (dp_owner)
            GNT_M0:  HWDATA = HWDATA_M0;
            GNT_M1:  HWDATA = HWDATA_M1;
            default: HWDATA = '0;
        endcase
    end

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            grant    <= GNT_NONE;
            dp_owner <= GNT_NONE;
            last     <= GNT_M1;
        end else if (HREADY) begin
            grant    <= sel;
            dp_owner <= bus.trans[1] ? sel : GNT_NONE;
            if (bus.trans[1])
                last <= sel;
        end
    end

    // A live request the bus did not accept this edge is parked until issued.
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            pend0 <= 1'b0;
            pend1 <= 1'b0;
            hold0 <= '0;
            hold1 <= '0;
        end else begin
            if (HREADY && sel == GNT_M0) begin
                pend0 <= 1'b0;
            end else if (live_v0) begin
                pend0 <= 1'b1;
                hold0 <= live0;
            end
            if (HREADY && sel == GNT_M1) begin
                pend1 <= 1'b0;
            end else if (live_v1) begin
                pend1 <= 1'b1;
                hold1 <= live1;
            end
        end
    end

endmodule

// File: tb/tb_ahblite_master_arbiter.sv
// Directed bench for ahblite_master_arbiter: per-cycle expectations go into a
// scoreboard queue as stimulus is driven and are drained after the outputs settle.
module tb_ahblite_master_arbiter;

    logic        HCLK, HRESET;
    logic [31:0] HADDR_M0, HWDATA_M0, HRDATA_M0, HADDR_M1, HWDATA_M1, HRDATA_M1;
    logic [1:0]  HTRANS_M0, HTRANS_M1;
    logic        HWRITE_M0, HMASTLOCK_M0, HREADY_M0, HRESP_M0;
    logic        HWRITE_M1, HMASTLOCK_M1, HREADY_M1, HRESP_M1;
    logic [2:0]  HSIZE_M0, HBURST_M0, HSIZE_M1, HBURST_M1;
    logic [3:0]  HPROT_M0, HPROT_M1;
    logic [31:0] HADDR, HWDATA, HRDATA;
    logic [1:0]  HTRANS;
    logic        HWRITE, HMASTLOCK, HREADY, HRESP;
    logic [2:0]  HSIZE, HBURST;
    logic [3:0]  HPROT;

    localparam logic [1:0] IDLE = 2'b00, NONSEQ = 2'b10, SEQ = 2'b11;

    localparam int S_HADDR = 0, S_HTRANS = 1, S_HWRITE = 2, S_HBURST = 3, S_HMASTLOCK = 4,
                   S_HWDATA = 5, S_HREADY_M0 = 6, S_HREADY_M1 = 7, S_HRESP_M0 = 8,
                   S_HRESP_M1 = 9, S_HRDATA_M0 = 10, S_HRDATA_M1 = 11;

    typedef struct {
        string       tag;
        int          sig;
        logic [31:0] val;
    } entry_t;

    entry_t sb[$];
    int checks = 0;
    int errors = 0;

    ahblite_master_arbiter dut (
        .HCLK(HCLK), .HRESET(HRESET),
        .HADDR_M0(HADDR_M0), .HTRANS_M0(HTRANS_M0), .HWRITE_M0(HWRITE_M0), .HSIZE_M0(HSIZE_M0),
        .HBURST_M0(HBURST_M0), .HPROT_M0(HPROT_M0), .HMASTLOCK_M0(HMASTLOCK_M0),
        .HWDATA_M0(HWDATA_M0), .HREADY_M0(HREADY_M0), .HRDATA_M0(HRDATA_M0), .HRESP_M0(HRESP_M0),
        .HADDR_M1(HADDR_M1), .HTRANS_M1(HTRANS_M1), .HWRITE_M1(HWRITE_M1), .HSIZE_M1(HSIZE_M1),
        .HBURST_M1(HBURST_M1), .HPROT_M1(HPROT_M1), .HMASTLOCK_M1(HMASTLOCK_M1),
        .HWDATA_M1(HWDATA_M1), .HREADY_M1(HREADY_M1), .HRDATA_M1(HRDATA_M1), .HRESP_M1(HRESP_M1),
        .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST),
        .HPROT(HPROT), .HMASTLOCK(HMASTLOCK), .HWDATA(HWDATA),
        .HREADY(HREADY), .HRDATA(HRDATA), .HRESP(HRESP)
    );

    initial begin
        HCLK = 1'b0;
        forever #5 HCLK = ~HCLK;
    end

    initial begin
        #100000;
        $display("FAIL timeout reached");
        $fatal(1);
    end

    function automatic logic [31:0] observe(input int s);
        case (s)
            S_HADDR:     return HADDR;
            S_HTRANS:    return {30'd0, HTRANS};
            S_HWRITE:    return {31'd0, HWRITE};
            S_HBURST:    return {29'd0, HBURST};
            S_HMASTLOCK: return {31'd0, HMASTLOCK};
            S_HWDATA:    return HWDATA;
            S_HREADY_M0: return {31'd0, HREADY_M0};
            S_HREADY_M1: return {31'd0, HREADY_M1};
            S_HRESP_M0:  return {31'd0, HRESP_M0};
            S_HRESP_M1:  return {31'd0, HRESP_M1};
            S_HRDATA_M0: return HRDATA_M0;
            S_HRDATA_M1: return HRDATA_M1;
            default:     return 32'hxxxx_xxxx;
        endcase
    endfunction

    task automatic want(input string tag, input int s, input logic [31:0] v);
        entry_t e;
        e.tag = tag;
        e.sig = s;
        e.val = v;
        sb.push_back(e);
    endtask

    task automatic drain();
        entry_t e;
        logic [31:0] obs;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            obs = observe(e.sig);
            checks++;
            assert (obs === e.val) else begin
                errors++;
                $error("FAIL %s observed %h expected %h", e.tag, obs, e.val);
            end
        end
    endtask

    task automatic step();
        @(posedge HCLK);
        #1;
    endtask

    task automatic check_cycle();
        #2;
        drain();
    endtask

    task automatic set_m0(input logic [31:0] a, input logic [1:0] t, input logic w, input logic l);
        HADDR_M0 = a; HTRANS_M0 = t; HWRITE_M0 = w; HMASTLOCK_M0 = l;
    endtask

    task automatic set_m1(input logic [31:0] a, input logic [1:0] t, input logic w, input logic l);
        HADDR_M1 = a; HTRANS_M1 = t; HWRITE_M1 = w; HMASTLOCK_M1 = l;
    endtask

    // Address values are left in place so the zero-fill of idle outputs is visible.
    task automatic idle_all();
        HTRANS_M0 = IDLE; HWRITE_M0 = 1'b0; HMASTLOCK_M0 = 1'b0; HBURST_M0 = 3'd0; HWDATA_M0 = '0;
        HTRANS_M1 = IDLE; HWRITE_M1 = 1'b0; HMASTLOCK_M1 = 1'b0; HBURST_M1 = 3'd0; HWDATA_M1 = '0;
        HSIZE_M0 = 3'b010; HSIZE_M1 = 3'b010; HPROT_M0 = 4'b0011; HPROT_M1 = 4'b0011;
        HREADY = 1'b1; HRESP = 1'b0; HRDATA = '0;
    endtask

    initial begin
        HADDR_M0 = '0;
        HADDR_M1 = '0;
        idle_all();
        HRESET = 1'b1;
        #3;
        want("rst_htrans", S_HTRANS, 0);
        want("rst_hready_m0", S_HREADY_M0, 1);
        want("rst_hready_m1", S_HREADY_M1, 1);
        want("rst_hresp_m0", S_HRESP_M0, 0);
        want("rst_hrdata_m1", S_HRDATA_M1, 0);
        want("rst_hwdata", S_HWDATA, 0);
        drain();
        step();
        HRESET = 1'b0;

        // single zero-wait read from M0
        set_m0(32'h2000_0000, NONSEQ, 1'b0, 1'b0);
        want("a_htrans", S_HTRANS, 2);
        want("a_haddr", S_HADDR, 32'h2000_0000);
        check_cycle();
        step();
        idle_all();
        HRDATA = 32'h1234_5678;
        want("a_hready_m0", S_HREADY_M0, 1);
        want("a_hrdata_m0", S_HRDATA_M0, 32'h1234_5678);
        want("a_hrdata_m1", S_HRDATA_M1, 0);
        want("a_idle_htrans", S_HTRANS, 0);
        want("a_idle_haddr", S_HADDR, 0);
        check_cycle();
        step();

        // simultaneous first requests after reset
        idle_all();
        HRESET = 1'b1;
        #1;
        HRESET = 1'b0;
        set_m0(32'h0000_0100, NONSEQ, 1'b0, 1'b0);
        set_m1(32'h2000_0000, NONSEQ, 1'b0, 1'b0);
        want("b_haddr_m0", S_HADDR, 32'h0000_0100);
        want("b_htrans", S_HTRANS, 2);
        want("b_hready_m1_c0", S_HREADY_M1, 1);
        check_cycle();
        step();
        idle_all();
        HRDATA = 32'hAAAA_0001;
        want("b_haddr_m1", S_HADDR, 32'h2000_0000);
        want("b_htrans_m1", S_HTRANS, 2);
        want("b_hready_m1_stall", S_HREADY_M1, 0);
        want("b_hready_m0", S_HREADY_M0, 1);
        want("b_hrdata_m0", S_HRDATA_M0, 32'hAAAA_0001);
        check_cycle();
        step();
        idle_all();
        HRDATA = 32'hBBBB_0002;
        want("b_hready_m1", S_HREADY_M1, 1);
        want("b_hrdata_m1", S_HRDATA_M1, 32'hBBBB_0002);
        want("b_hrdata_m0", S_HRDATA_M0, 0);
        want("b_htrans_idle", S_HTRANS, 0);
        check_cycle();
        step();

        // M1 INCR4 burst with M0 arriving on beat 2
        idle_all();
        HBURST_M1 = 3'b011;
        set_m1(32'h3000_0000, NONSEQ, 1'b0, 1'b0);
        want("c_beat1", S_HADDR, 32'h3000_0000);
        want("c_hburst", S_HBURST, 3);
        check_cycle();
        step();
        set_m1(32'h3000_0004, SEQ, 1'b0, 1'b0);
        set_m0(32'h0000_0400, NONSEQ, 1'b0, 1'b0);
        want("c_beat2", S_HADDR, 32'h3000_0004);
        want("c_beat2_htrans", S_HTRANS, 3);
        want("c_hready_m0_c1", S_HREADY_M0, 1);
        check_cycle();
        step();
        set_m0(32'h0000_0400, IDLE, 1'b0, 1'b0);
        set_m1(32'h3000_0008, SEQ, 1'b0, 1'b0);
        want("c_beat3", S_HADDR, 32'h3000_0008);
        want("c_hready_m0_c2", S_HREADY_M0, 0);
        check_cycle();
        step();
        set_m1(32'h3000_000C, SEQ, 1'b0, 1'b0);
        want("c_beat4", S_HADDR, 32'h3000_000C);
        want("c_hready_m0_c3", S_HREADY_M0, 0);
        check_cycle();
        step();
        HBURST_M1 = 3'b000;
        set_m1(32'h5000_0000, NONSEQ, 1'b0, 1'b0);
        want("c_rr_m0", S_HADDR, 32'h0000_0400);
        want("c_rr_htrans", S_HTRANS, 2);
        want("c_rr_hburst", S_HBURST, 0);
        want("c_hready_m1_c4", S_HREADY_M1, 1);
        check_cycle();
        step();
        set_m1(32'h5000_0000, IDLE, 1'b0, 1'b0);
        want("c_m1_next", S_HADDR, 32'h5000_0000);
        want("c_hready_m0_c5", S_HREADY_M0, 1);
        want("c_hready_m1_c5", S_HREADY_M1, 0);
        check_cycle();
        step();
        idle_all();
        want("c_end_htrans", S_HTRANS, 0);
        want("c_end_hready_m1", S_HREADY_M1, 1);
        check_cycle();
        step();

        // M0 locked read-modify-write while M1 keeps requesting
        set_m0(32'h0000_0600, NONSEQ, 1'b0, 1'b1);
        set_m1(32'h0000_0700, NONSEQ, 1'b0, 1'b0);
        want("d_rd_haddr", S_HADDR, 32'h0000_0600);
        want("d_rd_lock", S_HMASTLOCK, 1);
        check_cycle();
        step();
        set_m0(32'h0000_0600, NONSEQ, 1'b1, 1'b1);
        set_m1(32'h0000_0700, IDLE, 1'b0, 1'b0);
        want("d_wr_haddr", S_HADDR, 32'h0000_0600);
        want("d_wr_hwrite", S_HWRITE, 1);
        want("d_wr_lock", S_HMASTLOCK, 1);
        want("d_hready_m1_c1", S_HREADY_M1, 0);
        check_cycle();
        step();
        set_m0(32'h0000_0600, IDLE, 1'b0, 1'b0);
        HWDATA_M0 = 32'hCAFE_0001;
        want("d_hwdata", S_HWDATA, 32'hCAFE_0001);
        want("d_m1_issued", S_HADDR, 32'h0000_0700);
        want("d_unlock", S_HMASTLOCK, 0);
        want("d_hready_m1_c2", S_HREADY_M1, 0);
        check_cycle();
        step();
        idle_all();
        want("d_hready_m1_c3", S_HREADY_M1, 1);
        want("d_end_htrans", S_HTRANS, 0);
        check_cycle();
        step();

        // two-cycle ERROR to M1 write; M0 arrives during the first ERROR cycle
        set_m1(32'h0000_0800, NONSEQ, 1'b1, 1'b0);
        want("e_htrans", S_HTRANS, 2);
        want("e_haddr", S_HADDR, 32'h0000_0800);
        check_cycle();
        step();
        set_m1(32'h0000_0800, IDLE, 1'b0, 1'b0);
        HWDATA_M1 = 32'hDEAD_BEEF;
        HREADY = 1'b0;
        HRESP = 1'b1;
        set_m0(32'h0000_0900, NONSEQ, 1'b0, 1'b0);
        want("e_hwdata", S_HWDATA, 32'hDEAD_BEEF);
        want("e_err1_hresp_m1", S_HRESP_M1, 1);
        want("e_err1_hready_m1", S_HREADY_M1, 0);
        want("e_err1_hresp_m0", S_HRESP_M0, 0);
        want("e_err1_hready_m0", S_HREADY_M0, 1);
        check_cycle();
        step();
        set_m0(32'h0000_0900, IDLE, 1'b0, 1'b0);
        HREADY = 1'b1;
        want("e_err2_hresp_m1", S_HRESP_M1, 1);
        want("e_err2_hready_m1", S_HREADY_M1, 1);
        want("e_err2_hresp_m0", S_HRESP_M0, 0);
        want("e_err2_hready_m0", S_HREADY_M0, 0);
        want("e_m0_issued", S_HADDR, 32'h0000_0900);
        check_cycle();
        step();
        idle_all();
        want("e_hready_m0", S_HREADY_M0, 1);
        want("e_hresp_m0", S_HRESP_M0, 0);
        want("e_hresp_m1", S_HRESP_M1, 0);
        check_cycle();
        step();

        // reset while M1 is parked and M0 is wait-stated
        set_m0(32'h0000_0A00, NONSEQ, 1'b0, 1'b0);
        want("f_haddr", S_HADDR, 32'h0000_0A00);
        check_cycle();
        step();
        set_m0(32'h0000_0A00, IDLE, 1'b0, 1'b0);
        HREADY = 1'b0;
        set_m1(32'h0000_0B00, NONSEQ, 1'b0, 1'b0);
        want("f_wait_hready_m0", S_HREADY_M0, 0);
        want("f_hready_m1_c1", S_HREADY_M1, 1);
        check_cycle();
        step();
        set_m1(32'h0000_0B00, IDLE, 1'b0, 1'b0);
        want("f_pend_hready_m1", S_HREADY_M1, 0);
        check_cycle();
        HRESET = 1'b1;
        #1;
        want("f_rst_htrans", S_HTRANS, 0);
        want("f_rst_hready_m0", S_HREADY_M0, 1);
        want("f_rst_hready_m1", S_HREADY_M1, 1);
        want("f_rst_hrdata_m0", S_HRDATA_M0, 0);
        drain();
        step();
        HRESET = 1'b0;
        HREADY = 1'b1;
        want("f_post_htrans", S_HTRANS, 0);
        want("f_post_hready_m0", S_HREADY_M0, 1);
        want("f_post_hready_m1", S_HREADY_M1, 1);
        want("f_post_hwdata", S_HWDATA, 0);
        check_cycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
